// File: rtl/adc_conv_scheduler_if.sv
// adc_conv_scheduler_if
//   Bundles the control, SPI-read handshake and result handshake of the ADC
//   conversion scheduler.
//   slave  : scheduler side (drives cnv/spi_rd_req/result/status)
//   master : environment side (drives enable/period/clr_err/spi data/res_ready)
interface adc_conv_scheduler_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 16
);
  logic                    enable_i;
  logic [PERIOD_WIDTH-1:0] period_i;
  logic                    clr_err_i;
  logic                    cnv_o;
  logic                    spi_rd_req_o;
  logic                    spi_valid_i;
  logic [DATA_WIDTH-1:0]   spi_data_i;
  logic [DATA_WIDTH-1:0]   res_data_o;
  logic                    res_valid_o;
  logic                    res_ready_i;
  logic                    busy_o;
  logic                    overrun_o;
  logic                    timeout_o;

  modport slave (
    input  enable_i, period_i, clr_err_i, spi_valid_i, spi_data_i, res_ready_i,
    output cnv_o, spi_rd_req_o, res_data_o, res_valid_o, busy_o, overrun_o, timeout_o
  );

  modport master (
    output enable_i, period_i, clr_err_i, spi_valid_i, spi_data_i, res_ready_i,
    input  cnv_o, spi_rd_req_o, res_data_o, res_valid_o, busy_o, overrun_o, timeout_o
  );
endinterface

// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler
//   Runs periodic serial-ADC conversions: CNV pulse, conversion wait, SPI read
//   request, then averages 2^AVG_LOG2 samples into one ready/valid result.
//   Ports:
//     clk_adc : clock, rising edge
//     rst     : asynchronous active-high reset
//     bus     : adc_conv_scheduler_if.slave (enable/period/clr_err in,
//               cnv/spi_rd_req out, spi_valid/spi_data in, result handshake,
//               busy and sticky overrun/timeout flags)
module adc_conv_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int CNV_CYCLES     = 4,
  parameter int TCONV_CYCLES   = 64,
  parameter int AVG_LOG2       = 2,
  parameter int PERIOD_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_adc,
  input  logic                 rst,
  adc_conv_scheduler_if.slave  bus
);
  localparam int ACC_W = DATA_WIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int NAVG  = 1 << AVG_LOG2;
  localparam int TMAX0 = (CNV_CYCLES > TCONV_CYCLES) ? CNV_CYCLES : TCONV_CYCLES;
  localparam int TMAX  = (TMAX0 > TIMEOUT_CYCLES) ? TMAX0 : TIMEOUT_CYCLES;
  localparam int TMR_W = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, CNV, WAIT_CONV, READ, ACC, WAIT_PERIOD} state_t;

  state_t                  state;
  logic [TMR_W-1:0]        tmr;
  logic [PERIOD_WIDTH-1:0] per_cnt;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [DATA_WIDTH-1:0]   samp_q;
  logic [ACC_W-1:0]        acc;
  logic [CNT_W-1:0]        cnt;

  logic [ACC_W-1:0]        acc_sum;
  logic [ACC_W-1:0]        avg_res;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    avg_done;
  logic                    can_load;
  logic                    per_hit;
  logic                    ovr_set;
  logic                    to_set;

  always_comb begin
    acc_sum  = acc + ACC_W'(samp_q);
    avg_res  = acc_sum >> AVG_LOG2;
    cnt_inc  = cnt + 1'b1;
    avg_done = (cnt_inc == CNT_W'(NAVG));
    can_load = !bus.res_valid_o || bus.res_ready_i;
    // per_cnt is 0 in the first CNV cycle; "+1" makes CNV entries land exactly
    // period_q cycles apart.
    per_hit  = ({1'b0, per_cnt} + 1'b1) >= {1'b0, period_q};
    ovr_set  = (state == ACC) && avg_done && !can_load;
    to_set   = (state == READ) && !bus.spi_valid_i &&
               (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      tmr              <= '0;
      per_cnt          <= '0;
      period_q         <= '0;
      samp_q           <= '0;
      acc              <= '0;
      cnt              <= '0;
      bus.cnv_o        <= 1'b0;
      bus.spi_rd_req_o <= 1'b0;
      bus.res_data_o   <= '0;
      bus.res_valid_o  <= 1'b0;
      bus.busy_o       <= 1'b0;
      bus.overrun_o    <= 1'b0;
      bus.timeout_o    <= 1'b0;
    end else begin
      // saturate so a long period never wraps past the compare point
      if (per_cnt != '1) per_cnt <= per_cnt + 1'b1;

      // a new event in the clearing cycle wins
      bus.overrun_o <= (bus.overrun_o & ~bus.clr_err_i) | ovr_set;
      bus.timeout_o <= (bus.timeout_o & ~bus.clr_err_i) | to_set;

      if (bus.res_valid_o && bus.res_ready_i) bus.res_valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.enable_i) begin
            state      <= CNV;
            period_q   <= bus.period_i;
            per_cnt    <= '0;
            tmr        <= '0;
            bus.cnv_o  <= 1'b1;
            bus.busy_o <= 1'b1;
          end
        end
        CNV: begin
          tmr <= tmr + 1'b1;
          if (tmr == TMR_W'(CNV_CYCLES - 1)) begin
            state     <= WAIT_CONV;
            tmr       <= '0;
            bus.cnv_o <= 1'b0;
          end
        end
        WAIT_CONV: begin
          tmr <= tmr + 1'b1;
          if (tmr == TMR_W'(TCONV_CYCLES - 1)) begin
            state            <= READ;
            tmr              <= '0;
            bus.spi_rd_req_o <= 1'b1;
          end
        end
        READ: begin
          tmr <= tmr + 1'b1;
          if (bus.spi_valid_i) begin
            state            <= ACC;
            samp_q           <= bus.spi_data_i;
            bus.spi_rd_req_o <= 1'b0;
          end else if (to_set) begin
            // a lost sample poisons the running average: restart it
            state            <= WAIT_PERIOD;
            acc              <= '0;
            cnt              <= '0;
            bus.spi_rd_req_o <= 1'b0;
          end
        end
        ACC: begin
          state <= WAIT_PERIOD;
          if (avg_done) begin
            acc <= '0;
            cnt <= '0;
            if (can_load) begin
              bus.res_data_o  <= DATA_WIDTH'(avg_res);
              bus.res_valid_o <= 1'b1;
            end
          end else begin
            acc <= acc_sum;
            cnt <= cnt_inc;
          end
        end
        WAIT_PERIOD: begin
          if (!bus.enable_i) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            bus.busy_o <= 1'b0;
          end else if (per_hit) begin
            state     <= CNV;
            per_cnt   <= '0;
            tmr       <= '0;
            bus.cnv_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_conv_scheduler.sv
// tb_adc_conv_scheduler
//   Two schedulers (AVG_LOG2=0 and AVG_LOG2=2) share one stimulus stream.
//   A timeline model (cycles since conversion start) predicts every output and
//   is compared each cycle; directed literals pin the model.
module tb_adc_conv_scheduler;
  localparam int TCNV = 4, TWAIT = 64, TOUT = 255, LAT = 5;
  localparam int RD_K = TCNV + TWAIT;

  logic        clk_adc = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, clr = 1'b0, res_ready = 1'b0;
  logic [15:0] period = '0;
  logic        spi_valid = 1'b0;
  logic [15:0] spi_data = '0;

  int errors = 0, checks = 0;
  int cyc = 0;

  always #5 clk_adc = ~clk_adc;
  always @(posedge clk_adc) cyc <= cyc + 1;

  adc_conv_scheduler_if #(.DATA_WIDTH(16), .PERIOD_WIDTH(16)) if0 ();
  adc_conv_scheduler_if #(.DATA_WIDTH(16), .PERIOD_WIDTH(16)) if2 ();

  assign if0.enable_i = enable;   assign if2.enable_i = enable;
  assign if0.period_i = period;   assign if2.period_i = period;
  assign if0.clr_err_i = clr;     assign if2.clr_err_i = clr;
  assign if0.spi_valid_i = spi_valid; assign if2.spi_valid_i = spi_valid;
  assign if0.spi_data_i = spi_data;   assign if2.spi_data_i = spi_data;
  assign if0.res_ready_i = res_ready; assign if2.res_ready_i = res_ready;

  adc_conv_scheduler #(.AVG_LOG2(0)) u_dut0 (.clk_adc(clk_adc), .rst(rst), .bus(if0.slave));
  adc_conv_scheduler #(.AVG_LOG2(2)) u_dut2 (.clk_adc(clk_adc), .rst(rst), .bus(if2.slave));

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
    end
  endfunction

  // ---------------- SPI engine model ----------------
  logic [15:0] samp_q[$];
  bit never = 1'b0;
  int stray_cnt = 0, stray_done = 0, rq_cnt = 0;

  always @(negedge clk_adc) begin
    if (rst) begin
      rq_cnt = 0; spi_valid = 1'b0;
    end else if (stray_cnt != stray_done) begin
      spi_valid = 1'b1; spi_data = 16'hDEAD; stray_done++;
    end else begin
      spi_valid = 1'b0;
      if (if0.spi_rd_req_o) begin
        rq_cnt++;
        if (!never && rq_cnt == LAT) begin
          spi_valid = 1'b1;
          spi_data = (samp_q.size() > 0) ? samp_q.pop_front() : 16'h1234;
        end
      end else rq_cnt = 0;
    end
  end

  // ---------------- behavioural model ----------------
  // Conversion timeline: k = cycles since CNV entry. CNV for k<4, read
  // window from k=68 until the sample arrives or 255 cycles pass, one ACC
  // cycle, then wait until k+1 reaches the period (or drop to idle).
  int          avgl[2] = '{0, 2};
  bit          m_run, m_rdone, m_to, to_ev, acc_ev, stop, restart;
  int          m_k, m_acc_at, m_wp_from, m_P;
  logic [15:0] m_samp;
  longint      m_sum[2];
  int          m_n[2];
  bit          m_rv[2], m_ov[2], ov_ev[2], ld[2];
  logic [15:0] m_rd[2], res[2];

  always @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      m_run = 0; m_rdone = 0; m_to = 0; m_k = 0; m_acc_at = -1; m_wp_from = 1 << 30; m_P = 0;
      for (int i = 0; i < 2; i++) begin
        m_sum[i] = 0; m_n[i] = 0; m_rv[i] = 0; m_ov[i] = 0; m_rd[i] = '0;
      end
    end else begin
      to_ev = 0; acc_ev = 0; stop = 0; restart = 0;
      for (int i = 0; i < 2; i++) begin ov_ev[i] = 0; ld[i] = 0; end
      if (!m_run) begin
        if (enable) begin
          m_run = 1; m_k = 0; m_rdone = 0; m_acc_at = -1; m_wp_from = 1 << 30; m_P = period;
        end
      end else begin
        if (m_k >= RD_K && !m_rdone) begin
          if (spi_valid) begin
            m_rdone = 1; m_samp = spi_data; m_acc_at = m_k + 1;
          end else if (m_k - RD_K == TOUT - 1) begin
            m_rdone = 1; to_ev = 1; m_wp_from = m_k + 1;
            for (int i = 0; i < 2; i++) begin m_sum[i] = 0; m_n[i] = 0; end
          end
        end else if (m_k == m_acc_at) begin
          acc_ev = 1; m_wp_from = m_k + 1;
        end else if (m_k >= m_wp_from) begin
          if (!enable) stop = 1;
          else if (m_k + 1 >= m_P) restart = 1;
        end
        if (stop) begin
          m_run = 0;
          for (int i = 0; i < 2; i++) begin m_sum[i] = 0; m_n[i] = 0; end
        end else if (restart) begin
          m_k = 0; m_rdone = 0; m_acc_at = -1; m_wp_from = 1 << 30;
        end else m_k++;
      end
      if (acc_ev) begin
        for (int i = 0; i < 2; i++) begin
          m_sum[i] += m_samp; m_n[i]++;
          if (m_n[i] == (1 << avgl[i])) begin
            res[i] = 16'(m_sum[i] / (1 << avgl[i]));
            m_sum[i] = 0; m_n[i] = 0;
            if (!m_rv[i] || res_ready) ld[i] = 1; else ov_ev[i] = 1;
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (ld[i]) begin m_rv[i] = 1; m_rd[i] = res[i]; end
        else if (m_rv[i] && res_ready) m_rv[i] = 0;
        m_ov[i] = (m_ov[i] && !clr) || ov_ev[i];
      end
      m_to = (m_to && !clr) || to_ev;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_adc) begin
    if (!rst) begin
      chk("cnv0", if0.cnv_o, m_run && m_k < TCNV);
      chk("cnv2", if2.cnv_o, m_run && m_k < TCNV);
      chk("req0", if0.spi_rd_req_o, m_run && m_k >= RD_K && !m_rdone);
      chk("req2", if2.spi_rd_req_o, m_run && m_k >= RD_K && !m_rdone);
      chk("busy0", if0.busy_o, m_run);
      chk("busy2", if2.busy_o, m_run);
      chk("rv0", if0.res_valid_o, m_rv[0]);
      chk("rv2", if2.res_valid_o, m_rv[1]);
      chk("rd0", if0.res_data_o, m_rd[0]);
      chk("rd2", if2.res_data_o, m_rd[1]);
      chk("ov0", if0.overrun_o, m_ov[0]);
      chk("ov2", if2.overrun_o, m_ov[1]);
      chk("to0", if0.timeout_o, m_to);
      chk("to2", if2.timeout_o, m_to);
    end
  end

  // ---------------- edge trackers ----------------
  int rises[$], reqr[$];
  int rv2_rises = 0;
  logic p_cnv = 0, p_req = 0, p_rv2 = 0;
  always @(negedge clk_adc) begin
    if (if0.cnv_o && !p_cnv) rises.push_back(cyc);
    if (if0.spi_rd_req_o && !p_req) reqr.push_back(cyc);
    if (if2.res_valid_o && !p_rv2) rv2_rises++;
    p_cnv = if0.cnv_o; p_req = if0.spi_rd_req_o; p_rv2 = if2.res_valid_o;
  end

  task automatic wait_rises(input int n, input int maxc);
    int c = 0;
    while (rises.size() < n && c < maxc) begin @(negedge clk_adc); c++; end
    if (rises.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_rises got %0d want %0d", rises.size(), n);
    end
  endtask

  task automatic go_idle();
    int c = 0;
    enable = 1'b0;
    @(negedge clk_adc);
    while (if0.busy_o && c < 2000) begin @(negedge clk_adc); c++; end
    if (if0.busy_o) begin
      checks++; errors++;
      $display("FAIL go_idle busy got 1 want 0");
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1; @(negedge clk_adc); clr = 1'b0; @(negedge clk_adc);
  endtask

  initial begin
    int n0, c;
    repeat (3) @(negedge clk_adc);
    chk("rst_cnv", if0.cnv_o, 0);       chk("rst_busy", if2.busy_o, 0);
    chk("rst_rv", if0.res_valid_o, 0);  chk("rst_req", if2.spi_rd_req_o, 0);
    rst = 1'b0;
    @(negedge clk_adc);

    // T1: period 200, single samples, stray strobe outside READ
    period = 16'd200; res_ready = 1'b1; enable = 1'b1;
    wait_rises(1, 50);
    repeat (100) @(negedge clk_adc);
    stray_cnt++;
    wait_rises(5, 1200);
    chk("t1_spacing", rises[1] - rises[0], 200);
    chk("t1_spacing2", rises[4] - rises[3], 200);
    chk("t1_req_lat", reqr[0] - rises[0], 68);
    chk("t1_res0", if0.res_data_o, 16'h1234);
    chk("t1_res2", if2.res_data_o, 16'h1234);
    go_idle();

    // T2: averaging near full scale
    n0 = rises.size(); c = rv2_rises;
    samp_q = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFD};
    period = 16'd80; enable = 1'b1;
    wait_rises(n0 + 4, 600);
    go_idle();
    chk("t2_res0", if0.res_data_o, 16'hFFFD);
    chk("t2_res2", if2.res_data_o, 16'hFFFE);
    chk("t2_one_result", rv2_rises - c, 1);

    // T3: backpressure -> overrun, hold, clear, accept
    n0 = rises.size(); res_ready = 1'b0;
    samp_q = '{16'h10, 16'h20, 16'h30, 16'h40, 16'h50, 16'h60, 16'h70, 16'h80};
    period = 16'd80; enable = 1'b1;
    wait_rises(n0 + 8, 1000);
    go_idle();
    chk("t3_hold0", if0.res_data_o, 16'h0010);
    chk("t3_hold2", if2.res_data_o, 16'h0028);
    chk("t3_ov0", if0.overrun_o, 1);
    chk("t3_ov2", if2.overrun_o, 1);
    pulse_clr();
    chk("t3_clr_ov0", if0.overrun_o, 0);
    chk("t3_clr_ov2", if2.overrun_o, 0);
    res_ready = 1'b1; @(negedge clk_adc); res_ready = 1'b0; @(negedge clk_adc);
    chk("t3_taken0", if0.res_valid_o, 0);
    chk("t3_taken2", if2.res_valid_o, 0);

    // T4: read timeout discards the partial average
    n0 = rises.size(); res_ready = 1'b1;
    samp_q = '{16'h100, 16'h200};
    period = 16'd400; enable = 1'b1;
    wait_rises(n0 + 3, 1200);
    never = 1'b1;
    c = 0;
    while (!if0.timeout_o && c < 1000) begin @(negedge clk_adc); c++; end
    chk("t4_to0", if0.timeout_o, 1);
    chk("t4_to2", if2.timeout_o, 1);
    chk("t4_req_off", if0.spi_rd_req_o, 0);
    chk("t4_to_time", cyc - rises[n0 + 2], RD_K + TOUT);
    never = 1'b0;
    samp_q = '{16'h400, 16'h800, 16'hC00, 16'h1000};
    wait_rises(n0 + 4, 600);
    chk("t4_next_cnv", rises[n0 + 3] - rises[n0 + 2], 400);
    wait_rises(n0 + 7, 2000);
    go_idle();
    chk("t4_res0", if0.res_data_o, 16'h1000);
    chk("t4_res2", if2.res_data_o, 16'h0A00);
    pulse_clr();

    // T5: period below the minimum -> back-to-back
    n0 = rises.size();
    period = 16'd10; enable = 1'b1;
    wait_rises(n0 + 3, 400);
    chk("t5_b2b_a", rises[n0 + 1] - rises[n0], 75);
    chk("t5_b2b_b", rises[n0 + 2] - rises[n0 + 1], 75);
    go_idle();

    // T6: enable dropped during WAIT_CONV completes the sample
    n0 = rises.size(); res_ready = 1'b0;
    samp_q = '{16'h5A5A};
    period = 16'd200; enable = 1'b1;
    wait_rises(n0 + 1, 50);
    repeat (30) @(negedge clk_adc);
    enable = 1'b0;
    c = 0;
    while (if0.busy_o && c < 500) begin @(negedge clk_adc); c++; end
    chk("t6_busy", if0.busy_o, 0);
    chk("t6_res0", if0.res_data_o, 16'h5A5A);
    chk("t6_rv0", if0.res_valid_o, 1);
    repeat (300) @(negedge clk_adc);
    chk("t6_no_more_cnv", rises.size(), n0 + 1);

    // reset asserted mid-READ
    never = 1'b1; enable = 1'b1;
    c = 0;
    while (!if0.spi_rd_req_o && c < 400) begin @(negedge clk_adc); c++; end
    chk("t6_in_read", if0.spi_rd_req_o, 1);
    repeat (10) @(negedge clk_adc);
    #3 rst = 1'b1;
    #1;
    chk("arst_cnv", if0.cnv_o, 0);      chk("arst_req0", if0.spi_rd_req_o, 0);
    chk("arst_req2", if2.spi_rd_req_o, 0);
    chk("arst_rv", if0.res_valid_o, 0); chk("arst_rd", if0.res_data_o, 0);
    chk("arst_busy", if2.busy_o, 0);    chk("arst_ov", if2.overrun_o, 0);
    chk("arst_to", if0.timeout_o, 0);
    enable = 1'b0; never = 1'b0;
    @(negedge clk_adc);
    rst = 1'b0;
    repeat (5) @(negedge clk_adc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
